// File: rtl/mem_fs_responder.sv
// Filesystem-side responder: decodes the word-serial path into an open file and
// services single-word reads/writes against the /dev/mem and /dev/memmeta stores.
module mem_fs_responder #(
    parameter int MEM_AW  = 16,
    parameter int META_AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fsAccess,
    input  logic        fsRden,
    input  logic        fsWren,
    input  logic [31:0] fsFilename,
    input  logic [31:0] fsAddress,
    input  logic [31:0] fsData,
    output logic [31:0] fsQ,
    output logic [1:0]  fsOpen,
    output logic        fsErr
);
    localparam logic [31:0] W_DEV  = 32'h2F64_6576;  // "/dev"
    localparam logic [31:0] W_MEM  = 32'h2F6D_656D;  // "/mem"
    localparam logic [31:0] W_META = 32'h6D65_7461;  // "meta"

    localparam logic [1:0] F_NONE = 2'd0;
    localparam logic [1:0] F_MEM  = 2'd1;
    localparam logic [1:0] F_META = 2'd2;
    localparam logic [1:0] F_UNK  = 2'd3;

    logic [3:0][31:0] path_buf;
    logic [2:0]       path_len;
    logic [31:0]      last_name;

    logic             append, complete;
    logic [1:0]       decoded, eff_file;

    logic [31:0] mem_store  [0:(1<<MEM_AW)-1];
    logic [31:0] meta_store [0:(1<<META_AW)-1];

    logic [MEM_AW-1:0]  mem_idx;
    logic [META_AW-1:0] meta_idx;
    logic               mem_hit, meta_hit, req, valid;
    logic [31:0]        rd_word;

    always_comb begin
        append   = fsAccess && (fsFilename != '0) && (fsFilename != last_name);
        complete = fsAccess && (fsFilename == '0) && (last_name != '0);

        // A saturated (5+ word) path leaves path_len at 4, which never matches.
        decoded = F_UNK;
        if (path_len == 3'd2 && path_buf[0] == W_DEV && path_buf[1] == W_MEM)
            decoded = F_MEM;
        else if (path_len == 3'd3 && path_buf[0] == W_DEV && path_buf[1] == W_MEM &&
                 path_buf[2] == W_META && path_buf[3] == '0)
            decoded = F_META;

        // Requests on a completion edge already target the newly decoded file.
        eff_file = F_NONE;
        if (fsAccess)
            eff_file = complete ? decoded : fsOpen;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            path_buf  <= '0;
            path_len  <= '0;
            last_name <= '0;
            fsOpen    <= F_NONE;
        end else if (!fsAccess) begin
            path_buf  <= '0;
            path_len  <= '0;
            last_name <= '0;
            fsOpen    <= F_NONE;
        end else begin
            last_name <= fsFilename;
            if (complete) begin
                path_buf <= '0;
                path_len <= '0;
                fsOpen   <= decoded;
            end else if (append && path_len != 3'd4) begin
                path_buf[path_len[1:0]] <= fsFilename;
                path_len                <= path_len + 3'd1;
            end
        end
    end

    always_comb begin
        mem_idx  = fsAddress[MEM_AW-1:0];
        meta_idx = fsAddress[META_AW-1:0];
        mem_hit  = (eff_file == F_MEM)  && ((fsAddress >> MEM_AW)  == '0);
        meta_hit = (eff_file == F_META) && ((fsAddress >> META_AW) == '0);
        req      = fsRden || fsWren;
        valid    = mem_hit || meta_hit;
        rd_word  = mem_hit ? mem_store[mem_idx] : meta_store[meta_idx];
    end

    // Read sees the pre-write word since the store update is a separate NBA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsQ   <= '0;
            fsErr <= 1'b0;
        end else begin
            fsErr <= req && !valid;
            if (req && !valid)
                fsQ <= '0;
            else if (fsRden)
                fsQ <= rd_word;
        end
    end

    // Stores are deliberately outside reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (fsWren && mem_hit)
            mem_store[mem_idx] <= fsData;
        if (fsWren && meta_hit)
            meta_store[meta_idx] <= fsData;
    end
endmodule

// File: tb/tb_mem_fs_responder.sv
// Directed bench for mem_fs_responder: per-step expectations go through a
// scoreboard queue and are checked after the sampling edge.
module tb_mem_fs_responder;
    localparam logic [31:0] DEV  = 32'h2F64_6576;
    localparam logic [31:0] MEM  = 32'h2F6D_656D;
    localparam logic [31:0] META = 32'h6D65_7461;
    localparam logic [31:0] FOO  = 32'h2F66_6F6F;

    logic        clk = 1'b0;
    logic        rst;
    logic        fsAccess, fsRden, fsWren;
    logic [31:0] fsFilename, fsAddress, fsData;
    logic [31:0] fsQ;
    logic [1:0]  fsOpen;
    logic        fsErr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        bit          cq, co, ce;
        logic [31:0] q;
        logic [1:0]  op;
        logic        err;
    } exp_t;
    exp_t sb[$];

    mem_fs_responder #(.MEM_AW(16), .META_AW(8)) dut (
        .clk(clk), .rst(rst), .fsAccess(fsAccess), .fsRden(fsRden), .fsWren(fsWren),
        .fsFilename(fsFilename), .fsAddress(fsAddress), .fsData(fsData),
        .fsQ(fsQ), .fsOpen(fsOpen), .fsErr(fsErr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push its expectation, pop and compare after the edge.
    task automatic step(input bit acc, input bit rd, input bit wr,
                        input logic [31:0] name, input logic [31:0] addr, input logic [31:0] data,
                        input string tag,
                        input bit cq, input logic [31:0] q,
                        input bit co, input logic [1:0] op,
                        input bit ce, input logic err);
        exp_t e;
        fsAccess = acc; fsRden = rd; fsWren = wr;
        fsFilename = name; fsAddress = addr; fsData = data;
        e.tag = tag; e.cq = cq; e.co = co; e.ce = ce; e.q = q; e.op = op; e.err = err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.cq) chk({e.tag, ".q"}, fsQ, e.q);
        if (e.co) chk({e.tag, ".open"}, {30'd0, fsOpen}, {30'd0, e.op});
        if (e.ce) chk({e.tag, ".err"}, {31'd0, fsErr}, {31'd0, e.err});
    endtask

    task automatic name_step(input logic [31:0] name);
        step(1, 0, 0, name, 0, 0, "path", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic close_step();
        step(0, 0, 0, 0, 0, 0, "close", 0, 0, 1, 0, 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        fsAccess = 0; fsRden = 0; fsWren = 0;
        fsFilename = 0; fsAddress = 0; fsData = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.q", fsQ, 32'd0);
        chk("reset.open", {30'd0, fsOpen}, 32'd0);
        chk("reset.err", {31'd0, fsErr}, 32'd0);
        rst = 1'b0;

        // open /dev/mem with a write on the separator edge, then read it back
        name_step(DEV);
        name_step(MEM);
        step(1, 0, 1, 0, 32'h10, 32'hDEAD_BEEF, "open_mem_wr", 0, 0, 1, 1, 1, 0);
        step(1, 1, 0, 0, 32'h10, 0, "rd_10", 1, 32'hDEAD_BEEF, 1, 1, 1, 0);

        // streaming dump then restore-read, one word per cycle
        for (int a = 32'h1000; a < 32'h2000; a++)
            step(1, 0, 1, 0, a, a, "stream_wr", 0, 0, 0, 0, 1, 0);
        close_step();
        name_step(DEV);
        name_step(MEM);
        step(1, 0, 0, 0, 0, 0, "reopen_mem", 0, 0, 1, 1, 0, 0);
        for (int a = 32'h1000; a < 32'h2000; a++)
            step(1, 1, 0, 0, a, 0, "stream_rd", 1, a, 0, 0, 1, 0);

        // /dev/memmeta: write on completion edge, reopen, read back
        close_step();
        name_step(DEV);
        name_step(MEM);
        name_step(META);
        step(1, 0, 1, 0, 32'd3, 32'hA, "open_meta_wr", 0, 0, 1, 2, 1, 0);
        close_step();
        name_step(DEV);
        name_step(MEM);
        name_step(META);
        step(1, 0, 0, 0, 0, 0, "reopen_meta", 0, 0, 1, 2, 0, 0);
        step(1, 1, 0, 0, 32'd3, 0, "meta_rd3", 1, 32'hA, 1, 2, 1, 0);
        step(1, 1, 0, 0, 32'h100, 0, "meta_oor", 1, 0, 1, 2, 1, 1);

        // unknown path rejects requests
        close_step();
        name_step(DEV);
        name_step(FOO);
        step(1, 0, 0, 0, 0, 0, "open_foo", 0, 0, 1, 3, 1, 0);
        step(1, 1, 0, 0, 32'h10, 0, "foo_rd", 1, 0, 1, 3, 1, 1);
        step(1, 0, 0, 0, 0, 0, "foo_idle", 1, 0, 0, 0, 1, 0);

        // out-of-range /dev/mem write must not alias onto index 0
        close_step();
        name_step(DEV);
        name_step(MEM);
        step(1, 0, 1, 0, 32'h0, 32'h77, "wr_0", 0, 0, 1, 1, 1, 0);
        step(1, 0, 1, 0, 32'h0001_0000, 32'h55, "wr_oor", 1, 0, 1, 1, 1, 1);
        step(1, 1, 0, 0, 32'h0, 0, "rd_0", 1, 32'h77, 1, 1, 1, 0);

        // read-before-write on simultaneous rden/wren
        step(1, 0, 1, 0, 32'd5, 32'h11, "wr_5", 0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 0, 32'd5, 32'h22, "rmw_5", 1, 32'h11, 0, 0, 1, 0);
        step(1, 1, 0, 0, 32'd5, 0, "rd_5", 1, 32'h22, 0, 0, 1, 0);

        // request while fsAccess low is rejected
        step(0, 1, 0, 0, 32'd5, 0, "noacc_rd", 1, 0, 1, 0, 1, 1);

        // repeated identical words collapse into one append
        name_step(DEV);
        name_step(DEV);
        name_step(MEM);
        name_step(MEM);
        step(1, 0, 0, 0, 0, 0, "collapse", 0, 0, 1, 1, 1, 0);

        // five-word path saturates and decodes unknown
        close_step();
        name_step(DEV);
        name_step(MEM);
        name_step(META);
        name_step(FOO);
        name_step(DEV);
        step(1, 0, 0, 0, 0, 0, "overflow", 0, 0, 1, 3, 0, 0);

        // reset mid-path discards the partial path; fsQ clears immediately
        close_step();
        step(1, 1, 0, 0, 0, 0, "pre_rst", 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, "pre_rst2", 0, 0, 0, 0, 0, 0);
        close_step();
        name_step(DEV);
        name_step(MEM);
        step(1, 1, 0, 0, 32'd5, 0, "rd_5b", 1, 32'h22, 1, 1, 1, 0);
        close_step();
        name_step(DEV);
        rst = 1'b1;
        #1;
        chk("async_rst.q", fsQ, 32'd0);
        chk("async_rst.open", {30'd0, fsOpen}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        name_step(MEM);
        step(1, 0, 0, 0, 0, 0, "post_rst", 1, 0, 1, 3, 1, 0);

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: leftover=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
